// File: rtl/router_pkt_fifo_pkg.sv
// Shared defaults and header-field helpers for the router packet FIFO.
// Header word layout: length in the upper bits, destination address in the low LEN_LSB bits.
package router_pkt_fifo_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_DEPTH     = 16;
    localparam int unsigned DEF_LEN_LSB   = 2;
    localparam int unsigned DEF_AF_MARGIN = 2;

    function automatic int unsigned addr_w(int unsigned depth);
        return $clog2(depth);
    endfunction

    // Callers zero-extend the header word to 32 bits; DATA_W must stay below 32.
    function automatic logic [31:0] hdr_len(logic [31:0] hdr, int unsigned data_w,
                                            int unsigned len_lsb);
        logic [31:0] mask;
        mask = (32'd1 << data_w) - 32'd1;
        return (hdr & mask) >> len_lsb;
    endfunction

    function automatic logic [31:0] hdr_addr(logic [31:0] hdr, int unsigned len_lsb);
        return hdr & ((32'd1 << len_lsb) - 32'd1);
    endfunction

endpackage

// File: rtl/router_pkt_fifo_if.sv
// Write/read handshake and status bundle of one router output FIFO.
interface router_pkt_fifo_if
    import router_pkt_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
);
    localparam int unsigned FILL_W = $clog2(DEPTH) + 1;

    logic              write_en;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic              read_en;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              hdr_out;
    logic              pkt_done;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [FILL_W-1:0] fill_level;
    logic              ovf_err;
    logic              udf_err;

    modport master (
        output write_en, lfd_state, data_in, read_en,
        input  data_out, out_valid, hdr_out, pkt_done, empty, full, almost_full, fill_level,
               ovf_err, udf_err
    );

    modport slave (
        input  write_en, lfd_state, data_in, read_en,
        output data_out, out_valid, hdr_out, pkt_done, empty, full, almost_full, fill_level,
               ovf_err, udf_err
    );

endinterface

// File: rtl/router_pkt_fifo_mem.sv
// Storage array for the packet FIFO: one write port, one read port, no reset.
// The read is registered by the output stage of the top level.
module router_pkt_fifo_mem #(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Per-destination packet FIFO with read-side packet-length tracking, fill level and
// overflow/underflow pulses. Output word is driven to zero whenever no packet is in flight.
module router_pkt_fifo
    import router_pkt_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned LEN_LSB   = DEF_LEN_LSB,
    parameter int unsigned AF_MARGIN = DEF_AF_MARGIN
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           soft_reset,
    router_pkt_fifo_if.slave bus
);

    localparam int unsigned ADDR_W = addr_w(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned CNT_W  = DATA_W - LEN_LSB + 1;

    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              hdr_out_q, hdr_out_d;
    logic              out_valid_q, out_valid_d;
    logic              pkt_done_q, pkt_done_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;

    logic              empty, full, do_write, do_read;
    logic [PTR_W-1:0]  fill;
    logic [DATA_W:0]   rd_word;
    logic [CNT_W-1:0]  rd_len;

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                      (wptr_q[ADDR_W] != rptr_q[ADDR_W]);
    assign fill     = wptr_q - rptr_q;
    assign do_write = bus.write_en & ~full & ~soft_reset;
    assign do_read  = bus.read_en & ~empty & ~soft_reset;
    assign rd_len   = CNT_W'(hdr_len(32'(rd_word[DATA_W-1:0]), DATA_W, LEN_LSB));

    router_pkt_fifo_mem #(
        .WIDTH  (DATA_W + 1),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock   (clock),
        .wr_en   (do_write),
        .wr_addr (wptr_q[ADDR_W-1:0]),
        .wr_data ({bus.lfd_state, bus.data_in}),
        .rd_addr (rptr_q[ADDR_W-1:0]),
        .rd_data (rd_word)
    );

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        pkt_cnt_d   = pkt_cnt_q;
        data_out_d  = data_out_q;
        hdr_out_d   = hdr_out_q;
        out_valid_d = 1'b0;
        pkt_done_d  = 1'b0;
        ovf_d       = 1'b0;
        udf_d       = 1'b0;
        if (soft_reset) begin
            wptr_d     = '0;
            rptr_d     = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
            hdr_out_d  = 1'b0;
        end else begin
            ovf_d = bus.write_en & full;
            udf_d = bus.read_en & empty;
            if (do_write) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (do_read) begin
                rptr_d      = rptr_q + PTR_W'(1);
                data_out_d  = rd_word[DATA_W-1:0];
                hdr_out_d   = rd_word[DATA_W];
                out_valid_d = 1'b1;
                // A header always reloads, even if the previous packet was cut short.
                if (rd_word[DATA_W]) begin
                    pkt_cnt_d = rd_len + CNT_W'(1);
                end else if (pkt_cnt_q != '0) begin
                    pkt_cnt_d  = pkt_cnt_q - CNT_W'(1);
                    pkt_done_d = (pkt_cnt_q == CNT_W'(1));
                end
            end else if (udf_d || (pkt_cnt_q == '0)) begin
                data_out_d = '0;
                hdr_out_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            pkt_cnt_q   <= '0;
            data_out_q  <= '0;
            hdr_out_q   <= 1'b0;
            out_valid_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            data_out_q  <= data_out_d;
            hdr_out_q   <= hdr_out_d;
            out_valid_q <= out_valid_d;
            pkt_done_q  <= pkt_done_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.hdr_out     = hdr_out_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.pkt_done    = pkt_done_q;
    assign bus.ovf_err     = ovf_q;
    assign bus.udf_err     = udf_q;
    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.fill_level  = fill;
    assign bus.almost_full = ((PTR_W'(DEPTH) - fill) <= PTR_W'(AF_MARGIN));

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo (DATA_W=8, DEPTH=16, LEN_LSB=2, AF_MARGIN=2).
module tb_router_pkt_fifo;

    logic clock;
    logic resetn;
    logic soft_reset;
    int   total;
    int   bad;

    router_pkt_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

    router_pkt_fifo #(
        .DATA_W    (8),
        .DEPTH     (16),
        .LEN_LSB   (2),
        .AF_MARGIN (2)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic lfd, input logic [7:0] din, input logic re);
        bus.write_en  = we;
        bus.lfd_state = lfd;
        bus.data_in   = din;
        bus.read_en   = re;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        total++;
        if (bus.data_out !== 8'h00 || bus.out_valid !== 1'b0 || bus.empty !== 1'b1 ||
            bus.full !== 1'b0 || bus.fill_level !== 5'd0 || bus.pkt_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_init: dout=%h vld=%b empty=%b full=%b fill=%0d want 00/0/1/0/0",
                     bus.data_out, bus.out_valid, bus.empty, bus.full, bus.fill_level);
        end
        step();
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        total++;
        if (bus.fill_level !== 5'd5 || bus.out_valid !== 1'b1 || bus.data_out !== 8'h10) begin
            bad++;
            $display("FAIL reset_pre: fill=%0d vld=%b dout=%h want 5/1/10",
                     bus.fill_level, bus.out_valid, bus.data_out);
        end
        #2 resetn = 1'b0;
        #1;
        total++;
        if (bus.data_out !== 8'h00 || bus.out_valid !== 1'b0 || bus.empty !== 1'b1 ||
            bus.fill_level !== 5'd0) begin
            bad++;
            $display("FAIL reset_async: dout=%h vld=%b empty=%b fill=%0d want 00/0/1/0",
                     bus.data_out, bus.out_valid, bus.empty, bus.fill_level);
        end
        #1 resetn = 1'b1;
        step();
    endtask

    task automatic test_packet();
        logic [7:0] words [5];
        words = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5C};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (i == 0), words[i], 1'b0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            step();
            total++;
            if (bus.data_out !== words[i] || bus.hdr_out !== (i == 0) || bus.out_valid !== 1'b1 ||
                bus.pkt_done !== (i == 4)) begin
                bad++;
                $display("FAIL pkt_pop%0d: dout=%h hdr=%b vld=%b done=%b want %h/%b/1/%b", i,
                         bus.data_out, bus.hdr_out, bus.out_valid, bus.pkt_done, words[i],
                         (i == 0), (i == 4));
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        total++;
        if (bus.data_out !== 8'h00 || bus.out_valid !== 1'b0 || bus.pkt_done !== 1'b0 ||
            bus.empty !== 1'b1) begin
            bad++;
            $display("FAIL pkt_idle: dout=%h vld=%b done=%b empty=%b want 00/0/0/1",
                     bus.data_out, bus.out_valid, bus.pkt_done, bus.empty);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'h30 + 8'(i), 1'b0);
            step();
            total++;
            if (bus.almost_full !== (i >= 13) || bus.fill_level !== 5'(i + 1)) begin
                bad++;
                $display("FAIL full_af%0d: af=%b fill=%0d want %b/%0d", i, bus.almost_full,
                         bus.fill_level, (i >= 13), i + 1);
            end
        end
        total++;
        if (bus.full !== 1'b1) begin
            bad++;
            $display("FAIL full_flag: full=%b want 1", bus.full);
        end
        drive(1'b1, 1'b0, 8'hEE, 1'b0);
        step();
        total++;
        if (bus.ovf_err !== 1'b1 || bus.fill_level !== 5'd16) begin
            bad++;
            $display("FAIL full_ovf: ovf=%b fill=%0d want 1/16", bus.ovf_err, bus.fill_level);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        total++;
        if (bus.ovf_err !== 1'b0) begin
            bad++;
            $display("FAIL full_ovf_pulse: ovf=%b want 0", bus.ovf_err);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            step();
            total++;
            if (bus.data_out !== 8'h30 + 8'(i) || bus.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL full_pop%0d: dout=%h vld=%b want %h/1", i, bus.data_out,
                         bus.out_valid, 8'h30 + 8'(i));
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        total++;
        if (bus.empty !== 1'b1 || bus.data_out !== 8'h00) begin
            bad++;
            $display("FAIL full_drain: empty=%b dout=%h want 1/00", bus.empty, bus.data_out);
        end
    endtask

    task automatic test_simul();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0);
            step();
        end
        drive(1'b1, 1'b0, 8'h99, 1'b1);
        step();
        total++;
        if (bus.data_out !== 8'h40 || bus.fill_level !== 5'd15 || bus.ovf_err !== 1'b1) begin
            bad++;
            $display("FAIL simul_full: dout=%h fill=%0d ovf=%b want 40/15/1", bus.data_out,
                     bus.fill_level, bus.ovf_err);
        end
        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            step();
            total++;
            if (bus.data_out !== 8'h40 + 8'(i)) begin
                bad++;
                $display("FAIL simul_pop%0d: dout=%h want %h", i, bus.data_out, 8'h40 + 8'(i));
            end
        end
        drive(1'b1, 1'b0, 8'h77, 1'b1);
        step();
        total++;
        if (bus.udf_err !== 1'b1 || bus.out_valid !== 1'b0 || bus.fill_level !== 5'd1 ||
            bus.data_out !== 8'h00) begin
            bad++;
            $display("FAIL simul_empty: udf=%b vld=%b fill=%0d dout=%h want 1/0/1/00",
                     bus.udf_err, bus.out_valid, bus.fill_level, bus.data_out);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        step();
        total++;
        if (bus.data_out !== 8'h77 || bus.udf_err !== 1'b0 || bus.empty !== 1'b1) begin
            bad++;
            $display("FAIL simul_after: dout=%h udf=%b empty=%b want 77/0/1", bus.data_out,
                     bus.udf_err, bus.empty);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b0, 8'd3, 1'b0);
        step();
        for (int j = 1; j < 48; j++) begin
            drive(1'b1, 1'b0, 8'(j * 7 + 3), 1'b1);
            step();
            total++;
            if (bus.data_out !== 8'((j - 1) * 7 + 3) || bus.fill_level !== 5'd1) begin
                bad++;
                $display("FAIL wrap%0d: dout=%h fill=%0d want %h/1", j, bus.data_out,
                         bus.fill_level, 8'((j - 1) * 7 + 3));
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        step();
        total++;
        if (bus.data_out !== 8'(47 * 7 + 3) || bus.empty !== 1'b1) begin
            bad++;
            $display("FAIL wrap_last: dout=%h empty=%b want %h/1", bus.data_out, bus.empty,
                     8'(47 * 7 + 3));
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
    endtask

    task automatic test_soft_reset();
        drive(1'b1, 1'b1, 8'h15, 1'b0);
        step();
        drive(1'b1, 1'b0, 8'hB1, 1'b0);
        step();
        drive(1'b1, 1'b0, 8'hB2, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        step();
        step();
        drive(1'b1, 1'b0, 8'hCC, 1'b1);
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        total++;
        if (bus.empty !== 1'b1 || bus.fill_level !== 5'd0 || bus.data_out !== 8'h00 ||
            bus.out_valid !== 1'b0 || bus.hdr_out !== 1'b0) begin
            bad++;
            $display("FAIL soft_flush: empty=%b fill=%0d dout=%h vld=%b hdr=%b want 1/0/00/0/0",
                     bus.empty, bus.fill_level, bus.data_out, bus.out_valid, bus.hdr_out);
        end
        drive(1'b1, 1'b0, 8'hD1, 1'b0);
        step();
        drive(1'b1, 1'b0, 8'hD2, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        step();
        total++;
        if (bus.data_out !== 8'hD1 || bus.pkt_done !== 1'b0) begin
            bad++;
            $display("FAIL soft_pop: dout=%h done=%b want D1/0", bus.data_out, bus.pkt_done);
        end
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        // With the tracker cleared the idle output returns to zero instead of holding D2.
        total++;
        if (bus.data_out !== 8'h00 || bus.out_valid !== 1'b0 || bus.empty !== 1'b1) begin
            bad++;
            $display("FAIL soft_idle: dout=%h vld=%b empty=%b want 00/0/1", bus.data_out,
                     bus.out_valid, bus.empty);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        soft_reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        test_reset();
        test_packet();
        test_full();
        test_simul();
        test_wrap();
        test_soft_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
